// File: rtl/fb_mem_arb.sv
// Three-requester round-robin arbiter for one shared memory port.
// Each access runs IDLE -> BUSY -> RESP. A missing mem_ack ends BUSY after TIMEOUT cycles with err.
`ifndef FB_32BITS
`define FB_32BITS 31:0
`endif

module fb_mem_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        req,
  input  logic [`FB_32BITS] addr0,
  input  logic [`FB_32BITS] addr1,
  input  logic [`FB_32BITS] addr2,
  input  logic [`FB_32BITS] wdata0,
  input  logic [`FB_32BITS] wdata1,
  input  logic [`FB_32BITS] wdata2,
  input  logic [2:0]        we,
  output logic              mem_req,
  output logic [`FB_32BITS] mem_addr,
  output logic [`FB_32BITS] mem_wdata,
  output logic              mem_we,
  input  logic              mem_ack,
  input  logic [`FB_32BITS] mem_rdata,
  output logic              e00,
  output logic              e01,
  output logic              e11,
  output logic [2:0]        done,
  output logic              err,
  output logic [`FB_32BITS] rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // The counter holds the number of BUSY cycles already spent without mem_ack.
  // Therefore the cycle that reaches TIMEOUT is the one where the counter shows TIMEOUT-1.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [1:0]        gnt_q, last_q;
  logic [7:0]        cnt_q;
  logic              err_pend_q;
  logic [`FB_32BITS] addr_q, wdata_q, rdata_q;
  logic              we_q;

  logic [1:0]        cand0, cand1, pick;
  logic              timeout;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // The round-robin search starts one past the last-served requester.
  // The last-served requester is tried last.
  always_comb begin
    cand0 = next_idx(last_q);
    cand1 = next_idx(cand0);
    if (req[cand0])      pick = cand0;
    else if (req[cand1]) pick = cand1;
    else                 pick = last_q;
  end

  assign timeout = (cnt_q == CNT_LAST);

  // NOTE: every signal written here gets a default before the case statement.
  // Otherwise a path that skips the signal would infer a latch.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    done      = 3'b000;
    err       = 1'b0;
    case (state_q)
      IDLE: if (|req) state_d = BUSY;
      BUSY: begin
        mem_req = 1'b1;
        mem_we  = we_q;
        if (mem_ack || timeout) state_d = RESP;
      end
      RESP: begin
        done    = 3'b001 << gnt_q;
        err     = err_pend_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign e00   = done[0];
  assign e01   = done[1];
  assign e11   = done[2];
  assign rdata = rdata_q;

  // NOTE: sequential state uses non-blocking assignments only.
  // Then every flop samples pre-edge values, whatever order the statements run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q      <= 2'd0;
      last_q     <= 2'd2;
      cnt_q      <= 8'd0;
      err_pend_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (|req) begin
          gnt_q <= pick;
          we_q  <= we[pick];
          cnt_q <= 8'd0;
          case (pick)
            2'd0:    begin addr_q <= addr0; wdata_q <= wdata0; end
            2'd1:    begin addr_q <= addr1; wdata_q <= wdata1; end
            default: begin addr_q <= addr2; wdata_q <= wdata2; end
          endcase
        end
        BUSY: begin
          // mem_ack has priority when it arrives in the timeout cycle.
          if (mem_ack) begin
            rdata_q <= mem_rdata;
            cnt_q   <= 8'd0;
          end else if (timeout) begin
            rdata_q    <= '0;
            err_pend_q <= 1'b1;
            cnt_q      <= 8'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP: begin
          last_q     <= gnt_q;
          err_pend_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_mem_arb.sv
// Bench for fb_mem_arb (TIMEOUT=4).
// Runs table vectors, hand-written reset and idle-ack sequences, and random accesses checked by a transaction-level model.
module tb_fb_mem_arb;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, we_r;
  logic [31:0] a [3];
  logic [31:0] wd [3];
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, rdata;
  logic        e00, e01, e11, err;
  logic [2:0]  done;

  int n_tests = 0;
  int n_fail  = 0;
  int last_served = 2;

  always #5 clk = ~clk;

  fb_mem_arb #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .addr0(a[0]), .addr1(a[1]), .addr2(a[2]),
    .wdata0(wd[0]), .wdata1(wd[1]), .wdata2(wd[2]),
    .we(we_r), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .e00(e00), .e01(e01), .e11(e11), .done(done), .err(err), .rdata(rdata)
  );

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  we;
    int          d;      // BUSY cycle carrying mem_ack; larger than TO means no ack
    logic [31:0] data;
    logic [2:0]  done;   // expected
    bit          err;    // expected
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Round-robin rule: search from last+1 with wrap-around.
  function automatic int rr_pick(input logic [2:0] mask, input int last);
    for (int i = 1; i <= 3; i++)
      if (mask[(last + i) % 3]) return (last + i) % 3;
    return -1;
  endfunction

  // Starts at a negedge with the DUT idle and ends at the negedge of the following IDLE cycle.
  // req is left applied unless drop is set.
  task automatic run_txn(input logic [2:0] mask, input int d, input bit drop,
                         input logic [31:0] ack_data, input int exp_w, input bit exp_err);
    int n;
    logic [31:0] exp_rd;
    n = (d < TO) ? d : TO;
    exp_rd = exp_err ? 32'h0 : ack_data;
    req = mask;
    mem_ack = 1'($urandom_range(0, 1));   // ignored in IDLE
    mem_rdata = $urandom;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check("busy_mem_req", 32'(mem_req), 32'd1);
      check("busy_mem_addr", mem_addr, a[exp_w]);
      check("busy_mem_wdata", mem_wdata, wd[exp_w]);
      check("busy_mem_we", 32'(mem_we), 32'(we_r[exp_w]));
      check("busy_done", 32'(done), 32'd0);
      if (drop && k == 1) req = 3'b000;
      mem_ack = (k == d);
      mem_rdata = (k == d) ? ack_data : $urandom;
    end
    @(negedge clk);
    check("resp_done", 32'(done), 32'(3'b001 << exp_w));
    check("resp_sel", 32'({e11, e01, e00}), 32'(3'b001 << exp_w));
    check("resp_err", 32'(err), 32'(exp_err));
    check("resp_rdata", rdata, exp_rd);
    check("resp_mem_req", 32'(mem_req), 32'd0);
    last_served = exp_w;
    mem_ack = 1'($urandom_range(0, 1));   // ignored in RESP
    mem_rdata = $urandom;
    @(negedge clk);
    check("idle_done", 32'(done), 32'd0);
    check("idle_mem_req", 32'(mem_req), 32'd0);
    check("idle_sel", 32'({e11, e01, e00}), 32'd0);
    check("idle_err", 32'(err), 32'd0);
    mem_ack = 1'b0;
  endtask

  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [2:0] m;
    int d;

    tbl[0] = '{3'b001, 3'b000, 1, 32'hDEADBEEF, 3'b001, 1'b0};
    tbl[1] = '{3'b111, 3'b000, 1, 32'hA1A1A1A1, 3'b010, 1'b0};
    tbl[2] = '{3'b111, 3'b000, 2, 32'hA2A2A2A2, 3'b100, 1'b0};
    tbl[3] = '{3'b111, 3'b000, 1, 32'hA3A3A3A3, 3'b001, 1'b0};
    tbl[4] = '{3'b010, 3'b000, 9, 32'hBADBAD00, 3'b010, 1'b1};
    tbl[5] = '{3'b101, 3'b000, 3, 32'h55AA55AA, 3'b100, 1'b0};
    tbl[6] = '{3'b101, 3'b000, 4, 32'hCAFEF00D, 3'b001, 1'b0};
    tbl[7] = '{3'b100, 3'b100, 2, 32'h0BADF00D, 3'b100, 1'b0};
    tbl[8] = '{3'b011, 3'b011, 5, 32'h77777777, 3'b001, 1'b1};
    tbl[9] = '{3'b011, 3'b000, 1, 32'h13579BDF, 3'b010, 1'b0};

    rst_n = 1'b0; req = '0; we_r = '0; mem_ack = 1'b0; mem_rdata = '0;
    a[0] = 32'h100; a[1] = 32'h200; a[2] = 32'h300;
    wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h12345678;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_done_err", 32'({done, err, e11, e01, e00}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_mem_req", 32'(mem_req), 32'd0);

    for (int i = 0; i < 10; i++) begin
      we_r = tbl[i].we;
      w = tbl[i].done[0] ? 0 : (tbl[i].done[1] ? 1 : 2);
      run_txn(tbl[i].req, tbl[i].d, 1'b0, tbl[i].data, w, tbl[i].err);
    end
    req = 3'b000; we_r = 3'b000;

    // mem_ack pulsed while IDLE must not produce a response.
    mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
    @(negedge clk);
    mem_ack = 1'b0;
    check("idle_ack_mem_req", 32'(mem_req), 32'd0);
    check("idle_ack_done", 32'(done), 32'd0);
    @(negedge clk);
    check("idle_ack_done2", 32'(done), 32'd0);
    check("idle_ack_rdata", rdata, 32'h13579BDF);

    // Asynchronous reset in the middle of BUSY.
    req = 3'b010;
    @(negedge clk);
    check("pre_rst_mem_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_mem_req", 32'(mem_req), 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'h0);
    check("mid_rst_mem_we", 32'(mem_we), 32'd0);
    check("mid_rst_rdata", rdata, 32'h0);
    check("mid_rst_done_err", 32'({done, err, e11, e01, e00}), 32'd0);
    req = 3'b000;
    last_served = 2;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_mid_rst_done", 32'(done), 32'd0);
    check("post_mid_rst_mem_req", 32'(mem_req), 32'd0);
    run_txn(3'b011, 2, 1'b0, 32'h600DCAFE, rr_pick(3'b011, last_served), 1'b0);

    // Random accesses checked against the transaction-level model.
    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < 3; r++) begin
        a[r] = $urandom;
        wd[r] = $urandom;
      end
      we_r = 3'($urandom_range(0, 7));
      m = 3'($urandom_range(1, 7));
      d = $urandom_range(1, TO + 2);
      run_txn(m, d, 1'($urandom_range(0, 1)), $urandom, rr_pick(m, last_served), d > TO);
    end
    req = 3'b000;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_mem_arb.md
FB_MEM_ARB -- requirements
Module: fb_mem_arb

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles the arbiter waits for mem_ack before aborting an access.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req  in  3  per-requester access request; bit0 = fetch, bit1 = load/store, bit2 = debug.
REQ-005 addr0, addr1, addr2  in  `FB_32BITS each  requester addresses.
REQ-006 wdata0, wdata1, wdata2  in  `FB_32BITS each  requester write data.
REQ-007 we  in  3  per-requester write enable.
REQ-008 mem_req  out  1  shared memory port request.
REQ-009 mem_addr, mem_wdata  out  `FB_32BITS each  shared port address and write data.
REQ-010 mem_we  out  1  shared port write enable.
REQ-011 mem_ack  in  1  single-cycle completion pulse from memory.
REQ-012 mem_rdata  in  `FB_32BITS  memory read data, valid with mem_ack.
REQ-013 e00, e01, e11  out  1 each  one-hot return-data select enables for requesters 0, 1 and 2.
REQ-014 done  out  3  one-cycle completion pulse per requester.
REQ-015 err  out  1  pulses together with the done bit when an access times out.
REQ-016 rdata  out  `FB_32BITS  registered read data returned to the requester whose done bit is set.

Function
REQ-017 The FSM SHALL have states IDLE, BUSY and RESP, encoded in 2 bits.
REQ-018 IDLE: if any req bit is set, grant exactly one requester using round-robin from the last-served index plus 1 (mod 3), latch its index, addr, wdata and we, then go to BUSY.
REQ-019 IDLE with req == 0: remain in IDLE; mem_req = 0.
REQ-020 BUSY: mem_req = 1; mem_addr, mem_wdata and mem_we SHALL be driven from the latched values and held stable until exit.
REQ-021 BUSY with mem_ack = 1: capture mem_rdata into rdata, clear the timeout counter, go to RESP.
REQ-022 BUSY: an 8-bit counter SHALL increment each cycle without mem_ack; on reaching TIMEOUT, set rdata = 0 and err_pending, then go to RESP.
REQ-023 RESP: assert done[g] and the select enable for the granted requester g for exactly 1 cycle; assert err in the same cycle if err_pending; set last-served = g; clear err_pending; go to IDLE.
REQ-024 e00/e01/e11 SHALL be 0 outside RESP and SHALL never have more than one bit set.
REQ-025 Request-to-done latency SHALL be 1 (grant) + N (cycles up to and including mem_ack) + 1 (RESP); minimum 3 cycles with mem_ack in the first BUSY cycle.
REQ-026 Back-to-back: a new grant SHALL occur no earlier than the cycle after RESP (IDLE re-evaluates req).
REQ-027 A requester SHALL hold req and its operands until its done pulse; deassertion during BUSY does not abort the access.
REQ-028 mem_ack received in IDLE or RESP SHALL be ignored.
REQ-029 mem_ack and timeout in the same cycle: mem_ack wins, no err.
REQ-030 Round-robin wrap: after requester 2 is served, the priority order SHALL be 0, 1, 2.

Reset
REQ-031 While rst_n = 0: state = IDLE, last-served = 2 (so requester 0 has first priority), counter = 0, err_pending = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, rdata = 0, done = 0, err = 0, e00 = e01 = e11 = 0.
REQ-032 Reset asserted mid-access SHALL abort the access immediately with no done pulse; after release, the FSM starts in IDLE.

Verification
REQ-033 req = 3'b001 with addr0 = 0x100, mem_ack on the first BUSY cycle with mem_rdata = 0xDEADBEEF -> done = 3'b001, e00 = 1 and rdata = 0xDEADBEEF, 3 cycles after the request.
REQ-034 req = 3'b111 held for three accesses -> grant order 0, 1, 2, and exactly one of e00/e01/e11 is set in each RESP cycle.
REQ-035 req = 3'b010, mem_ack never asserted, TIMEOUT = 4 -> done[1] = 1, err = 1 and rdata = 0 in the RESP cycle after the 4th BUSY cycle.
REQ-036 Write from requester 2, we[2] = 1, wdata2 = 0x12345678 -> mem_we = 1 and mem_wdata = 0x12345678, stable until mem_ack.
REQ-037 rst_n pulsed low during BUSY -> all outputs reach their reset values asynchronously, no done pulse; the next request is granted normally.
REQ-038 mem_ack pulsed while in IDLE -> no done pulse, no state change.
